pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline stall/flush/redirect controller for the 5-stage core. Sits beside the IF/ID and ID/EX pipeline registers and drives their stall and flush controls. Resolves load-use hazards, multi-cycle MDU operations, MEM back-pressure, branch mispredicts, traps and `mret` under one fixed priority. Owns the trap-flush sequence and the redirect source select handed to the PC generator.

## Interface
- `TRAP_FLUSH_CYCLES`, 2: cycles the front end is held flushed after a trap or `mret` (legal 1..15).
- `clk` in 1: core clock.
- `rst` in 1: synchronous, active-high reset.
- `id_rs1_idx`, `id_rs2_idx` in `REG_IDX_WIDTH`: source registers of the instruction in ID.
- `id_rs1_ren`, `id_rs2_ren` in 1: source actually read.
- `id_ex_rd_idx` in `REG_IDX_WIDTH`, `id_ex_rd_en` in 1, `id_ex_is_load` in 1: destination info of the instruction in EX.
- `ex_mispredict` in 1: EX branch resolution disagrees with `prdt_taken`.
- `ex_excp` in 1: OR of all IF/ID/EX exception flags for the instruction in EX.
- `ex_mret` in 1: `mret` in EX.
- `ex_mdu_req` in 1: EX holds a multi-cycle mul/div.
- `mdu_done` in 1: MDU result valid this cycle.
- `mem_busy` in 1: MEM stage cannot accept (LSU wait).
- `if_stall`, `if_id_stall`, `id_ex_stall` out 1: hold the corresponding register.
- `if_id_flush`, `id_ex_flush` out 1: load a bubble (all-zero, `rd_en`=0, exception flags 0).
- `ex_mem_bubble` out 1: EX result not valid this cycle.
- `redirect_valid` out 1, `redirect_sel` out 2: PC redirect (`REDIR_BRANCH`=1, `REDIR_TRAP`=2, `REDIR_MRET`=3, 0 when idle).
- `trap_commit`, `mret_commit` out 1: single-cycle pulses to the CSR unit.

## Operation
- FSM states: `RUN`, `MDU_WAIT`, `FLUSH`. A 4-bit `flush_cnt` tracks the flush sequence.
- Priority in `RUN` (highest first):
  1. **`mem_busy`**: assert all three stalls. Assert `ex_mem_bubble`=0 (hold). No flush, no redirect, no commit pulse. EX inputs are re-presented later.
  2. **`ex_excp`**: `trap_commit`=1, `redirect_valid`=1, `redirect_sel`=`REDIR_TRAP`, both flushes=1. Load `flush_cnt`=`TRAP_FLUSH_CYCLES`-1 and go to `FLUSH`; if that count is 0, stay in `RUN`.
  3. **`ex_mret`**: same as the trap case, but `mret_commit` pulses instead and `redirect_sel`=`REDIR_MRET`.
  4. **`ex_mispredict`**: `redirect_valid`=1, `redirect_sel`=`REDIR_BRANCH`, both flushes=1, no state change. Overrides any load-use stall.
  5. **`ex_mdu_req` && !`mdu_done`**: all three stalls=1, `ex_mem_bubble`=1, go to `MDU_WAIT`. If `mdu_done` is already high, pass through with no stall.
  6. **Load-use hazard**: `if_stall`=1, `if_id_stall`=1, `id_ex_flush`=1.
- **`MDU_WAIT`**: hold all stalls and `ex_mem_bubble` until `mdu_done`. In the `mdu_done` cycle, release everything and go to `RUN`. `mem_busy` still forces a hold. `ex_excp`, `ex_mret` and `ex_mispredict` are ignored here.
- **`FLUSH`**: both flushes=1, all stalls=0, no redirect. All EX-side inputs are ignored. Decrement `flush_cnt`; at 0, go to `RUN`.
- **Hazard match**: `id_rsN_ren` && `id_ex_rd_en` && `id_ex_rd_idx`==`id_rsN_idx` && `id_rsN_idx`!=0.
- All outputs are combinational from state plus inputs. Only state and `flush_cnt` are registered.

## Timing
- **Reset**: while `rst`=1, outputs are `if_id_flush`=`id_ex_flush`=1 and all else 0. The next edge gives state=`RUN`, `flush_cnt`=0. Reset mid-`MDU_WAIT` or mid-`FLUSH` aborts to `RUN` with no commit pulse.
- **Redirect**: zero-latency; asserted in the same cycle the cause is seen. Commit pulses last exactly 1 cycle per event.
- **Load-use**: costs 1 bubble. The stall drops the cycle after the load leaves EX.
- **Trap / `mret`**: 1 redirect cycle plus `TRAP_FLUSH_CYCLES`-1 `FLUSH` cycles.
- **MDU**: stalls for N cycles until `mdu_done`, with no extra cycle on release.

## Configuration
- `PIPE_CTRL_FULL_BYPASS_EN` defined: EX→ID forwarding exists. A hazard stalls only when `id_ex_is_load`=1.
- Undefined: no forwarding. Any hazard match stalls one cycle regardless of `id_ex_is_load`.

## Structure
- `defines.v` entries:
  - `REDIR_*` encodings.
  - `PIPE_CTRL_ST_*` state encodings (2-bit).
  - `PIPE_CTRL_CNT_WIDTH` (4).
- Sub-module `hazard_det`: combinational RAW compare producing `raw_hit`. `PIPE_CTRL_FULL_BYPASS_EN` gates `id_ex_is_load` inside it.

## Test plan
- **Load-use**: `id_ex_rd_idx`=5 with `rd_en`=1 and `is_load`=1, `id_rs1_idx`=5 with `ren`=1. Expect `if_stall`=`if_id_stall`=`id_ex_flush`=1 for 1 cycle. Repeat with `rd_idx`=0 and expect no stall.
- **Mispredict plus load-use, same cycle**: expect `redirect_sel`=1, both flushes=1, stalls=0.
- **Trap**: `ex_excp` pulse with default parameters. Expect `trap_commit`=1 and `redirect_sel`=2 in cycle 0, flushes=1 in cycles 0–1, `RUN` in cycle 2. Reran with `TRAP_FLUSH_CYCLES`=1, expect the return to `RUN` next cycle.
- **MDU**: `ex_mdu_req`=1 with `mdu_done` arriving 4 cycles later. Expect stalls for 4 cycles, release in the `mdu_done` cycle, and `ex_excp` asserted meanwhile ignored.
- **`mem_busy` with `ex_mispredict`**: expect no redirect while busy. Redirect fires in the first cycle `mem_busy`=0.
- **Reset mid-`FLUSH`**: assert `rst` in `FLUSH`. Expect flushes=1, all else 0, and `RUN` after release. Rerun with and without `PIPE_CTRL_FULL_BYPASS_EN` on a non-load RAW: expect 0 and 1 stall respectively.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared widths, redirect encodings and controller state type.
`default_nettype none

package pipe_ctrl_pkg;

  localparam int REG_IDX_WIDTH       = 5;
  localparam int PIPE_CTRL_CNT_WIDTH = 4;

  localparam logic [1:0] REDIR_NONE   = 2'd0;
  localparam logic [1:0] REDIR_BRANCH = 2'd1;
  localparam logic [1:0] REDIR_TRAP   = 2'd2;
  localparam logic [1:0] REDIR_MRET   = 2'd3;

  typedef enum logic [1:0] {
    PIPE_CTRL_ST_RUN      = 2'd0,
    PIPE_CTRL_ST_MDU_WAIT = 2'd1,
    PIPE_CTRL_ST_FLUSH    = 2'd2
  } pipe_state_e;

  // x0 is hard-wired zero, so it can never carry a real dependency.
  function automatic logic src_match(input logic                     ren,
                                     input logic [REG_IDX_WIDTH-1:0] src_idx,
                                     input logic                     rd_en,
                                     input logic [REG_IDX_WIDTH-1:0] rd_idx);
    return ren && rd_en && (rd_idx == src_idx) && (src_idx != '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_hazard_det.sv
// pipe_ctrl_hazard_det: ID-vs-EX RAW compare; PIPE_CTRL_FULL_BYPASS_EN limits hits to loads.
`default_nettype none

module pipe_ctrl_hazard_det
  import pipe_ctrl_pkg::*;
(
  input  logic                     id_rs1_ren,
  input  logic [REG_IDX_WIDTH-1:0] id_rs1_idx,
  input  logic                     id_rs2_ren,
  input  logic [REG_IDX_WIDTH-1:0] id_rs2_idx,
  input  logic                     id_ex_rd_en,
  input  logic [REG_IDX_WIDTH-1:0] id_ex_rd_idx,
  input  logic                     id_ex_is_load,
  output logic                     raw_hit
);

  logic any_match;

  assign any_match = src_match(id_rs1_ren, id_rs1_idx, id_ex_rd_en, id_ex_rd_idx) ||
                     src_match(id_rs2_ren, id_rs2_idx, id_ex_rd_en, id_ex_rd_idx);

`ifdef PIPE_CTRL_FULL_BYPASS_EN
  // EX results are forwarded, only a load's data arrives too late.
  assign raw_hit = any_match && id_ex_is_load;
`else
  logic unused_is_load;
  assign unused_is_load = id_ex_is_load;
  assign raw_hit        = any_match;
`endif

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush/redirect controller for the 5-stage core.
// Optional build macro: PIPE_CTRL_FULL_BYPASS_EN (forwarding present, only load-use stalls).
`default_nettype none

module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TRAP_FLUSH_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [REG_IDX_WIDTH-1:0] id_rs1_idx,
  input  logic [REG_IDX_WIDTH-1:0] id_rs2_idx,
  input  logic                     id_rs1_ren,
  input  logic                     id_rs2_ren,
  input  logic [REG_IDX_WIDTH-1:0] id_ex_rd_idx,
  input  logic                     id_ex_rd_en,
  input  logic                     id_ex_is_load,
  input  logic                     ex_mispredict,
  input  logic                     ex_excp,
  input  logic                     ex_mret,
  input  logic                     ex_mdu_req,
  input  logic                     mdu_done,
  input  logic                     mem_busy,
  output logic                     if_stall,
  output logic                     if_id_stall,
  output logic                     id_ex_stall,
  output logic                     if_id_flush,
  output logic                     id_ex_flush,
  output logic                     ex_mem_bubble,
  output logic                     redirect_valid,
  output logic [1:0]               redirect_sel,
  output logic                     trap_commit,
  output logic                     mret_commit
);

  localparam logic [PIPE_CTRL_CNT_WIDTH-1:0] FLUSH_LOAD =
    PIPE_CTRL_CNT_WIDTH'(TRAP_FLUSH_CYCLES - 1);

  pipe_state_e                    state_q, state_d;
  logic [PIPE_CTRL_CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
  logic                           raw_hit;

  pipe_ctrl_hazard_det u_hazard_det (
    .id_rs1_ren    (id_rs1_ren),
    .id_rs1_idx    (id_rs1_idx),
    .id_rs2_ren    (id_rs2_ren),
    .id_rs2_idx    (id_rs2_idx),
    .id_ex_rd_en   (id_ex_rd_en),
    .id_ex_rd_idx  (id_ex_rd_idx),
    .id_ex_is_load (id_ex_is_load),
    .raw_hit       (raw_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= PIPE_CTRL_ST_RUN;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    flush_cnt_d    = flush_cnt_q;
    if_stall       = 1'b0;
    if_id_stall    = 1'b0;
    id_ex_stall    = 1'b0;
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    ex_mem_bubble  = 1'b0;
    redirect_valid = 1'b0;
    redirect_sel   = REDIR_NONE;
    trap_commit    = 1'b0;
    mret_commit    = 1'b0;

    if (rst) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else begin
      unique case (state_q)
        PIPE_CTRL_ST_RUN: begin
          if (mem_busy) begin
            // EX keeps its result; it is re-presented once MEM accepts.
            if_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_stall = 1'b1;
          end else if (ex_excp || ex_mret) begin
            redirect_valid = 1'b1;
            redirect_sel   = ex_excp ? REDIR_TRAP : REDIR_MRET;
            trap_commit    = ex_excp;
            mret_commit    = !ex_excp;
            if_id_flush    = 1'b1;
            id_ex_flush    = 1'b1;
            if (FLUSH_LOAD != '0) begin
              state_d     = PIPE_CTRL_ST_FLUSH;
              flush_cnt_d = FLUSH_LOAD;
            end
          end else if (ex_mispredict) begin
            redirect_valid = 1'b1;
            redirect_sel   = REDIR_BRANCH;
            if_id_flush    = 1'b1;
            id_ex_flush    = 1'b1;
          end else if (ex_mdu_req && !mdu_done) begin
            if_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            ex_mem_bubble = 1'b1;
            state_d       = PIPE_CTRL_ST_MDU_WAIT;
          end else if (raw_hit) begin
            if_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
          end
        end

        PIPE_CTRL_ST_MDU_WAIT: begin
          if (mem_busy) begin
            if_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_stall = 1'b1;
          end else if (mdu_done) begin
            state_d = PIPE_CTRL_ST_RUN;
          end else begin
            if_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            ex_mem_bubble = 1'b1;
          end
        end

        PIPE_CTRL_ST_FLUSH: begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          if (flush_cnt_q <= PIPE_CTRL_CNT_WIDTH'(1)) begin
            flush_cnt_d = '0;
            state_d     = PIPE_CTRL_ST_RUN;
          end else begin
            flush_cnt_d = flush_cnt_q - PIPE_CTRL_CNT_WIDTH'(1);
          end
        end

        default: begin
          state_d     = PIPE_CTRL_ST_RUN;
          flush_cnt_d = '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed literal checks plus random stimulus against a behavioural model,
// run on two instances (TRAP_FLUSH_CYCLES = 2 and 1).
`default_nettype none

module tb_pipe_ctrl;

  // Output vector layout: {if_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush,
  //                        ex_mem_bubble, redirect_valid, redirect_sel[1:0], trap_commit, mret_commit}
  localparam logic [10:0] E_IDLE  = 11'b000_00_0_0_00_00;
  localparam logic [10:0] E_RST   = 11'b000_11_0_0_00_00;
  localparam logic [10:0] E_FLUSH = 11'b000_11_0_0_00_00;
  localparam logic [10:0] E_BUSY  = 11'b111_00_0_0_00_00;
  localparam logic [10:0] E_MDU   = 11'b111_00_1_0_00_00;
  localparam logic [10:0] E_TRAP  = 11'b000_11_0_1_10_10;
  localparam logic [10:0] E_MRET  = 11'b000_11_0_1_11_01;
  localparam logic [10:0] E_BRCH  = 11'b000_11_0_1_01_00;
  localparam logic [10:0] E_LDUSE = 11'b110_01_0_0_00_00;
`ifdef PIPE_CTRL_FULL_BYPASS_EN
  localparam logic [10:0] E_NONLOAD_RAW = E_IDLE;
`else
  localparam logic [10:0] E_NONLOAD_RAW = E_LDUSE;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] rs1, rs2, rd;
  logic       ren1, ren2, rd_en, is_load, misp, excp, mret, mdu_req, mdu_done, mem_busy;
  wire  [10:0] a_o, b_o;

  int n_chk  = 0;
  int n_pass = 0;

  pipe_ctrl #(.TRAP_FLUSH_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst),
    .id_rs1_idx(rs1), .id_rs2_idx(rs2), .id_rs1_ren(ren1), .id_rs2_ren(ren2),
    .id_ex_rd_idx(rd), .id_ex_rd_en(rd_en), .id_ex_is_load(is_load),
    .ex_mispredict(misp), .ex_excp(excp), .ex_mret(mret),
    .ex_mdu_req(mdu_req), .mdu_done(mdu_done), .mem_busy(mem_busy),
    .if_stall(a_o[10]), .if_id_stall(a_o[9]), .id_ex_stall(a_o[8]),
    .if_id_flush(a_o[7]), .id_ex_flush(a_o[6]), .ex_mem_bubble(a_o[5]),
    .redirect_valid(a_o[4]), .redirect_sel(a_o[3:2]),
    .trap_commit(a_o[1]), .mret_commit(a_o[0])
  );

  pipe_ctrl #(.TRAP_FLUSH_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst),
    .id_rs1_idx(rs1), .id_rs2_idx(rs2), .id_rs1_ren(ren1), .id_rs2_ren(ren2),
    .id_ex_rd_idx(rd), .id_ex_rd_en(rd_en), .id_ex_is_load(is_load),
    .ex_mispredict(misp), .ex_excp(excp), .ex_mret(mret),
    .ex_mdu_req(mdu_req), .mdu_done(mdu_done), .mem_busy(mem_busy),
    .if_stall(b_o[10]), .if_id_stall(b_o[9]), .id_ex_stall(b_o[8]),
    .if_id_flush(b_o[7]), .id_ex_flush(b_o[6]), .ex_mem_bubble(b_o[5]),
    .redirect_valid(b_o[4]), .redirect_sel(b_o[3:2]),
    .trap_commit(b_o[1]), .mret_commit(b_o[0])
  );

  task automatic chk(input string name, input logic [10:0] got, input logic [10:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
  endtask

  // Reference: 'mdu' = waiting on a multi-cycle op, 'left' = flush cycles still owed.
  task automatic model(input int t, input bit mdu, input int left,
                       output logic [10:0] e, output bit nmdu, output int nleft);
    bit h;
    e     = E_IDLE;
    nmdu  = mdu;
    nleft = left;
    h = (ren1 && rs1 != 0 && rd_en && rd == rs1) || (ren2 && rs2 != 0 && rd_en && rd == rs2);
`ifdef PIPE_CTRL_FULL_BYPASS_EN
    h = h && is_load;
`endif
    if (rst) begin
      e = E_RST; nmdu = 1'b0; nleft = 0;
    end else if (left > 0) begin
      e = E_FLUSH; nleft = left - 1;
    end else if (mem_busy) begin
      e = E_BUSY;
    end else if (mdu) begin
      if (mdu_done) nmdu = 1'b0;
      else          e = E_MDU;
    end else if (excp) begin
      e = E_TRAP; nleft = t - 1;
    end else if (mret) begin
      e = E_MRET; nleft = t - 1;
    end else if (misp) begin
      e = E_BRCH;
    end else if (mdu_req && !mdu_done) begin
      e = E_MDU; nmdu = 1'b1;
    end else if (h) begin
      e = E_LDUSE;
    end
  endtask

  bit          ma = 1'b0, mb = 1'b0, na = 1'b0, nb = 1'b0;
  int          la = 0, lb = 0, nla = 0, nlb = 0;
  logic [10:0] ea, eb;

  always @(negedge clk) begin
    model(2, ma, la, ea, na, nla);
    model(1, mb, lb, eb, nb, nlb);
    chk("model_a", a_o, ea);
    chk("model_b", b_o, eb);
  end

  always @(posedge clk) begin
    ma <= na; la <= nla;
    mb <= nb; lb <= nlb;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rst = 1'b0; rs1 = '0; rs2 = '0; rd = '0;
    ren1 = 1'b0; ren2 = 1'b0; rd_en = 1'b0; is_load = 1'b0;
    misp = 1'b0; excp = 1'b0; mret = 1'b0; mdu_req = 1'b0; mdu_done = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic load_use5();
    rd = 5'd5; rd_en = 1'b1; is_load = 1'b1; rs1 = 5'd5; ren1 = 1'b1;
  endtask

  initial begin
    clr();
    rst = 1'b1;
    @(negedge clk);
    chk("reset_a", a_o, E_RST);
    chk("reset_b", b_o, E_RST);

    step(); clr(); load_use5();
    @(negedge clk); chk("load_use", a_o, E_LDUSE);
    step(); clr();
    @(negedge clk); chk("load_use_release", a_o, E_IDLE);
    step(); rd = '0; rd_en = 1'b1; is_load = 1'b1; rs1 = '0; ren1 = 1'b1;
    @(negedge clk); chk("rd_zero_no_stall", a_o, E_IDLE);

    step(); clr(); load_use5(); misp = 1'b1;
    @(negedge clk); chk("misp_over_loaduse", a_o, E_BRCH);

    step(); clr(); excp = 1'b1;
    @(negedge clk); chk("trap_c0_a", a_o, E_TRAP); chk("trap_c0_b", b_o, E_TRAP);
    step(); clr(); misp = 1'b1;
    @(negedge clk); chk("trap_c1_a_flush", a_o, E_FLUSH); chk("trap_c1_b_run", b_o, E_BRCH);
    step();
    @(negedge clk); chk("trap_c2_a_run", a_o, E_BRCH);

    step(); clr(); mdu_req = 1'b1;
    @(negedge clk); chk("mdu_c0", a_o, E_MDU);
    for (int i = 1; i < 4; i++) begin
      step(); excp = 1'b1;
      @(negedge clk); chk("mdu_wait_excp_ignored", a_o, E_MDU);
    end
    step(); excp = 1'b0; mdu_done = 1'b1;
    @(negedge clk); chk("mdu_release", a_o, E_IDLE);

    step(); clr(); mem_busy = 1'b1; misp = 1'b1;
    @(negedge clk); chk("busy_no_redirect", a_o, E_BUSY);
    step();
    @(negedge clk); chk("busy_no_redirect_2", a_o, E_BUSY);
    step(); mem_busy = 1'b0;
    @(negedge clk); chk("redirect_after_busy", a_o, E_BRCH);

    step(); clr(); mret = 1'b1;
    @(negedge clk); chk("mret_c0", a_o, E_MRET);
    step(); clr(); rst = 1'b1; excp = 1'b1;
    @(negedge clk); chk("rst_in_flush", a_o, E_RST);
    step(); clr(); misp = 1'b1;
    @(negedge clk); chk("run_after_rst", a_o, E_BRCH);

    step(); clr(); rd = 5'd7; rd_en = 1'b1; rs2 = 5'd7; ren2 = 1'b1;
    @(negedge clk); chk("nonload_raw", a_o, E_NONLOAD_RAW);

    repeat (3000) begin
      step();
      rst      = ($urandom_range(0, 49) == 0);
      rs1      = 5'($urandom_range(0, 3));
      rs2      = 5'($urandom_range(0, 3));
      rd       = 5'($urandom_range(0, 3));
      ren1     = 1'($urandom_range(0, 1));
      ren2     = 1'($urandom_range(0, 1));
      rd_en    = 1'($urandom_range(0, 1));
      is_load  = 1'($urandom_range(0, 1));
      misp     = ($urandom_range(0, 9) == 0);
      excp     = ($urandom_range(0, 19) == 0);
      mret     = ($urandom_range(0, 19) == 0);
      mdu_req  = ($urandom_range(0, 4) == 0);
      mdu_done = ($urandom_range(0, 2) == 0);
      mem_busy = ($urandom_range(0, 6) == 0);
    end
    step();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
